// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Issues fetches at pc, advances by 4 on each accepted fetch, redirects on
// aligned branch targets (one bubble cycle), and flags misaligned targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] Branchtarget,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        misalign_err,
    output logic [15:0] branch_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_BUBBLE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        misalign_q, misalign_d;
    logic [15:0] branch_count_q, branch_count_d;

    logic        target_aligned_s;
    logic        redirect_s;
    logic        bad_target_s;
    logic [31:0] pc_inc_s;

    // Saturating increment for the redirect counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign target_aligned_s = (Branchtarget[1:0] == 2'b00);
    // Branches are only honoured once the sequencer has left IDLE.
    assign redirect_s       = branch_taken && target_aligned_s && (state_q != S_IDLE);
    assign bad_target_s     = branch_taken && !target_aligned_s && (state_q != S_IDLE);
    assign pc_inc_s         = pc_q + 32'd4;

    // Next-state and next-register computation; redirect outranks stall and ready.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pc_plus4_d     = pc_plus4_q;
        fetch_valid_d  = 1'b0;
        misalign_d     = misalign_q | bad_target_s;
        branch_count_d = branch_count_q;

        if (redirect_s) begin
            // Any fetch in flight this cycle is discarded.
            pc_d           = Branchtarget;
            branch_count_d = sat_inc16(branch_count_q);
            state_d        = S_BUBBLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH, S_WAIT: begin
                    if (stall) begin
                        state_d = state_q;
                    end else if (imem_ready) begin
                        pc_d          = pc_inc_s;
                        pc_plus4_d    = pc_inc_s;
                        fetch_valid_d = 1'b1;
                        state_d       = S_FETCH;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_BUBBLE: begin
                    if (stall) begin
                        state_d = S_BUBBLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            pc_plus4_q     <= RESET_PC + 32'd4;
            fetch_valid_q  <= 1'b0;
            misalign_q     <= 1'b0;
            branch_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pc_plus4_q     <= pc_plus4_d;
            fetch_valid_q  <= fetch_valid_d;
            misalign_q     <= misalign_d;
            branch_count_q <= branch_count_d;
        end
    end

    // Request is a pure decode of the state register, so no input reaches it.
    assign imem_req     = (state_q == S_FETCH) || (state_q == S_WAIT);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_q;
    assign fetch_valid  = fetch_valid_q;
    assign misalign_err = misalign_q;
    assign branch_count = branch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: two instances (RESET_PC 0 and FFFF_FFF8) driven with the
// same inputs and compared each cycle against a behavioural model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] Branchtarget;
    logic        imem_ready;

    logic        req_o   [2];
    logic [31:0] addr_o  [2];
    logic [31:0] pc_o    [2];
    logic [31:0] p4_o    [2];
    logic        fv_o    [2];
    logic        err_o   [2];
    logic [15:0] cnt_o   [2];

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase 0 = just out of reset, 1 = fetching, 2 = bubble.
    logic [31:0] rst_pc [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_p4   [2];
    logic        m_fv   [2];
    logic        m_err  [2];
    logic [15:0] m_cnt  [2];
    int          m_ph   [2];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .Branchtarget(Branchtarget), .imem_ready(imem_ready),
        .imem_req(req_o[0]), .imem_addr(addr_o[0]), .pc(pc_o[0]), .pc_plus4(p4_o[0]),
        .fetch_valid(fv_o[0]), .misalign_err(err_o[0]), .branch_count(cnt_o[0])
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .Branchtarget(Branchtarget), .imem_ready(imem_ready),
        .imem_req(req_o[1]), .imem_addr(addr_o[1]), .pc(pc_o[1]), .pc_plus4(p4_o[1]),
        .fetch_valid(fv_o[1]), .misalign_err(err_o[1]), .branch_count(cnt_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pc[k]  = rst_pc[k];
                m_p4[k]  = rst_pc[k] + 32'd4;
                m_fv[k]  = 1'b0;
                m_err[k] = 1'b0;
                m_cnt[k] = 16'd0;
                m_ph[k]  = 0;
            end else begin
                m_fv[k] = 1'b0;
                if (m_ph[k] == 0) begin
                    m_ph[k] = 1;
                end else if (branch_taken && Branchtarget[1:0] == 2'b00) begin
                    m_pc[k]  = Branchtarget;
                    m_cnt[k] = (m_cnt[k] == 16'hFFFF) ? 16'hFFFF : m_cnt[k] + 16'd1;
                    m_ph[k]  = 2;
                end else begin
                    if (branch_taken) m_err[k] = 1'b1;
                    if (stall) begin
                        m_ph[k] = m_ph[k];
                    end else if (m_ph[k] == 2) begin
                        m_ph[k] = 1;
                    end else if (imem_ready) begin
                        m_p4[k] = m_pc[k] + 32'd4;
                        m_pc[k] = m_p4[k];
                        m_fv[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk(k == 0 ? "a.pc" : "b.pc", pc_o[k], m_pc[k]);
            chk(k == 0 ? "a.addr" : "b.addr", addr_o[k], m_pc[k]);
            chk(k == 0 ? "a.pc_plus4" : "b.pc_plus4", p4_o[k], m_p4[k]);
            chk(k == 0 ? "a.fetch_valid" : "b.fetch_valid", {31'd0, fv_o[k]}, {31'd0, m_fv[k]});
            chk(k == 0 ? "a.misalign" : "b.misalign", {31'd0, err_o[k]}, {31'd0, m_err[k]});
            chk(k == 0 ? "a.count" : "b.count", {16'd0, cnt_o[k]}, {16'd0, m_cnt[k]});
            chk(k == 0 ? "a.imem_req" : "b.imem_req", {31'd0, req_o[k]},
                {31'd0, (m_ph[k] == 1) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic cyc(input logic rs, input logic st, input logic br,
                       input logic [31:0] tgt, input logic rdy);
        rst_n        = rs;
        stall        = st;
        branch_taken = br;
        Branchtarget = tgt;
        imem_ready   = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] t;
        rst_pc[0] = 32'h0000_0000;
        rst_pc[1] = 32'hFFFF_FFF8;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'd0; m_p4[k] = 32'd0; m_fv[k] = 1'b0;
            m_err[k] = 1'b0; m_cnt[k] = 16'd0; m_ph[k] = 0;
        end
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        Branchtarget = 32'd0; imem_ready = 1'b0;
        #2;

        // Reset for three edges.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst.pc", pc_o[0], 32'h0000_0000);
        chk("rst.pc_plus4", p4_o[0], 32'h0000_0004);
        chk("rst.req", {31'd0, req_o[0]}, 32'd0);

        // IDLE cycle, then straight-line fetches.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("idle.fv", {31'd0, fv_o[0]}, 32'd0);
        chk("idle.pc", pc_o[0], 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq.pc4", pc_o[0], 32'h0000_0004);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("seq.pc8", pc_o[0], 32'h0000_0008);
        chk("wrap.pc", pc_o[1], 32'h0000_0000);
        chk("wrap.pc_plus4", p4_o[1], 32'h0000_0000);
        chk("wrap.noflag", {31'd0, err_o[1]}, 32'd0);

        // Memory not ready: WAIT holds pc with request high.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("wait.pc", pc_o[0], 32'h0000_0008);
        chk("wait.req", {31'd0, req_o[0]}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wait.accept", pc_o[0], 32'h0000_000C);

        // Redirect beats stall and ready.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
        chk("br.pc", pc_o[0], 32'h0000_0100);
        chk("br.count", {16'd0, cnt_o[0]}, 32'd1);
        chk("br.bubble_req", {31'd0, req_o[0]}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("br.fetch", pc_o[0], 32'h0000_0104);

        // Misaligned target: flag set, normal advance.
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b1);
        chk("mis.flag", {31'd0, err_o[0]}, 32'd1);
        chk("mis.pc", pc_o[0], 32'h0000_0108);
        chk("mis.count", {16'd0, cnt_o[0]}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("mis.sticky", {31'd0, err_o[0]}, 32'd1);

        // Reset during WAIT.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rstw.pc", pc_o[1], 32'hFFFF_FFF8);
        chk("rstw.flag", {31'd0, err_o[0]}, 32'd0);
        chk("rstw.count", {16'd0, cnt_o[0]}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
            cyc(($urandom_range(39, 0) != 0), ($urandom_range(3, 0) == 0),
                ($urandom_range(4, 0) == 0), t, ($urandom_range(2, 0) != 0));
        end

        // Counter saturation.
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            cyc(1'b1, i[0], 1'b1, {i[29:0], 2'b00}, 1'b1);
        end
        chk("sat.count", {16'd0, cnt_o[0]}, 32'h0000_FFFF);
        chk("sat.count_b", {16'd0, cnt_o[1]}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
